clk_ratio_checker: RTL and testbench
====================================

CLK_RATIO_CHECKER -- requirements
Module: clk_ratio_checker

Interface
REQ-001 Parameter EXP_RATIO, default 10: expected clk100 cycles per mon_clk period.
REQ-002 Parameter TOL, default 0: allowed absolute deviation from EXP_RATIO.
REQ-003 Parameter SETTLE_EDGES, default 10: mon_clk rising edges discarded after lock.
REQ-004 Parameter N_MEAS, default 4: consecutive good windows required for pass.
REQ-005 Parameter CNT_W, default 16: period counter width.
REQ-006 Parameter TIMEOUT_CYC, default 20000: no-edge limit in clk100 cycles (200 us).
REQ-007 clk100  input  1  reference clock, 100 MHz; the block's only clock.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 mon_clk  input  1  monitored clock (PLL output), asynchronous to clk100.
REQ-010 locked  input  1  PLL lock indication, asynchronous.
REQ-011 ratio_cnt  output  CNT_W  last measured window length in clk100 cycles.
REQ-012 ratio_valid  output  1  one-cycle pulse when ratio_cnt updates.
REQ-013 pass  output  1  high in state PASS.
REQ-014 fail  output  1  sticky failure flag.
REQ-015 timeout  output  1  sticky no-edge flag.
REQ-016 err_cnt  output  8  count of out-of-tolerance windows, saturates at 255.
REQ-017 led  output  1  equals pass.

Function
REQ-018 mon_clk and locked SHALL each pass through a two-flop synchronizer; mon_rise SHALL be a one-cycle pulse on a synchronized 0->1 transition.
REQ-019 Window length SHALL be the count of clk100 rising edges after one mon_rise, up to and including the next mon_rise; a /10 clock yields 10.
REQ-020 Period counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 FSM states: IDLE, SETTLE, MEASURE, PASS, FAIL.
REQ-022 IDLE -> SETTLE when synchronized locked=1; counters cleared.
REQ-023 SETTLE -> MEASURE after SETTLE_EDGES mon_rise pulses; the edge that completes SETTLE opens the first window.
REQ-024 MEASURE/PASS: each window close SHALL load ratio_cnt and pulse ratio_valid in the same cycle.
REQ-025 Good window: |count-EXP_RATIO| <= TOL; bad window: increment err_cnt, go FAIL next cycle.
REQ-026 MEASURE -> PASS after N_MEAS consecutive good windows; PASS keeps measuring.
REQ-027 Synchronized locked=0 in SETTLE, MEASURE or PASS -> IDLE; pass clears; no ratio_valid that cycle (locked loss wins over window close).
REQ-028 FAIL SHALL be sticky until reset, ignoring locked and mon_clk; fail=1 throughout.

Reset
REQ-029 rst_n=0 sampled at a clk100 edge SHALL force IDLE, synchronizer flops 0, ratio_cnt=0, ratio_valid=0, pass=0, fail=0, timeout=0, err_cnt=0, led=0, including mid-window.
REQ-030 First window after reset release SHALL require full SETTLE again.

Configuration
REQ-031 Macro CLK_CHK_TIMEOUT_EN defined: in SETTLE, MEASURE, PASS, counter reaching TIMEOUT_CYC without mon_rise SHALL set timeout=1, fail=1, go FAIL.
REQ-032 Macro undefined: no timeout logic; timeout tied 0; stopped mon_clk only saturates counter.

Structure
REQ-033 Package clk_chk_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-034 Sub-module sync_edge (2-flop synchronizer plus rise detector) SHALL be instantiated for mon_clk, synchronizer part reused for locked.

Verification
REQ-035 mon_clk=clk100/10, locked rises at 1 us -> after 10 settle edges, 4 ratio_valid pulses with ratio_cnt=10, pass=1, led=1, err_cnt=0.
REQ-036 mon_clk=clk100/12, TOL=0 -> first ratio_cnt=12, fail=1 sticky, err_cnt=1, pass=0.
REQ-037 locked held 0 for 300 us -> state IDLE, no ratio_valid, led=0, fail=0.
REQ-038 locked drops in PASS, relocks 5 us later -> pass=0 within 3 cycles, pass=1 again after settle + 4 good windows.
REQ-039 mon_clk stopped in PASS: with CLK_CHK_TIMEOUT_EN, timeout=1 and fail=1 after 20000 cycles; without it, fail stays 0.
REQ-040 rst_n=0 for one cycle mid-MEASURE -> all outputs 0 next edge; PASS reached again only after full SETTLE.

Source files
------------

// File: rtl/clk_chk_pkg.sv
// clk_chk_pkg
//   Shared definitions for the clock-ratio checker:
//   - state_t        : checker FSM states
//   - DEF_*          : default parameter values for clk_ratio_checker
//   - in_tol()       : absolute-deviation tolerance test for a window length
package clk_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam int DEF_EXP_RATIO    = 10;
  localparam int DEF_TOL          = 0;
  localparam int DEF_SETTLE_EDGES = 10;
  localparam int DEF_N_MEAS       = 4;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_TIMEOUT_CYC  = 20000;

  // True when |count - exp_ratio| <= tol, computed without signed wrap.
  function automatic logic in_tol(input int unsigned count,
                                  input int unsigned exp_ratio,
                                  input int unsigned tol);
    int unsigned diff;
    diff = (count > exp_ratio) ? (count - exp_ratio) : (exp_ratio - count);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Bank of two-flop synchronizers with a rising-edge detector on bit 0.
//   Bit 0 carries the signal whose edges matter (mon_clk); higher bits reuse
//   the same synchronizer for level-only signals (locked).
// Ports:
//   clk100  in   destination clock
//   rst_n   in   synchronous active-low reset (all flops to 0)
//   din     in   WIDTH asynchronous inputs
//   dout    out  WIDTH synchronized levels
//   rise    out  one-cycle pulse on a synchronized 0->1 of din[0]
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk100,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rise
);

  logic [WIDTH-1:0] meta;
  logic             prev;

  // NOTE: reset is synchronous (sampled inside the clocked block) and all
  // state updates use non-blocking assignments so flops update together.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
      prev <= dout[0];
    end
  end

  assign rise = dout[0] & ~prev;

endmodule

// File: rtl/clk_ratio_checker.sv
// clk_ratio_checker
//   Measures the period of mon_clk in clk100 cycles after PLL lock, discards
//   SETTLE_EDGES edges, then requires N_MEAS consecutive in-tolerance windows
//   to assert pass. Any out-of-tolerance window latches fail until reset.
//   Optional macro CLK_CHK_TIMEOUT_EN adds a no-edge watchdog (TIMEOUT_CYC).
// Ports:
//   clk100       in   100 MHz reference, only clock
//   rst_n        in   synchronous active-low reset
//   mon_clk      in   monitored clock, asynchronous
//   locked       in   PLL lock, asynchronous
//   ratio_cnt    out  last window length in clk100 cycles
//   ratio_valid  out  one-cycle pulse when ratio_cnt updates
//   pass         out  high in PASS
//   fail         out  high in FAIL (sticky until reset)
//   timeout      out  sticky no-edge flag (0 without CLK_CHK_TIMEOUT_EN)
//   err_cnt      out  out-of-tolerance window count, saturating
//   led          out  copy of pass
module clk_ratio_checker
  import clk_chk_pkg::*;
#(
  parameter int EXP_RATIO    = DEF_EXP_RATIO,
  parameter int TOL          = DEF_TOL,
  parameter int SETTLE_EDGES = DEF_SETTLE_EDGES,
  parameter int N_MEAS       = DEF_N_MEAS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic             clk100,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             locked,
  output logic [CNT_W-1:0] ratio_cnt,
  output logic             ratio_valid,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [7:0]       err_cnt,
  output logic             led
);

  localparam int SET_W  = (SETTLE_EDGES > 1) ? $clog2(SETTLE_EDGES) : 1;
  localparam int GOOD_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_EDGES - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(N_MEAS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state, state_n;
  logic [1:0]        sync_bits;
  logic              locked_s;
  logic              mon_rise;
  logic              unused_mon_level;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_len;
  logic [SET_W-1:0]  settle_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              win_close;
  logic              win_good;
  logic              cnt_expired;

  sync_edge #(.WIDTH(2)) u_sync (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .din    ({locked, mon_clk}),
    .dout   (sync_bits),
    .rise   (mon_rise)
  );

  assign locked_s         = sync_bits[1];
  assign unused_mon_level = sync_bits[0];

  // cnt holds edges seen since the window opened, so the closing edge itself
  // makes the window length cnt+1. Saturates rather than wrapping.
  assign cnt_len  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign win_good = in_tol(32'(cnt_len), EXP_RATIO, TOL);

`ifdef CLK_CHK_TIMEOUT_EN
  assign cnt_expired = (32'(cnt) >= 32'(TIMEOUT_CYC));
`else
  assign cnt_expired = 1'b0;
`endif

  always_ff @(posedge clk100) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    win_close = 1'b0;
    case (state)
      ST_IDLE: begin
        if (locked_s) state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_n = ST_IDLE;
        end else if (mon_rise) begin
          // The edge completing SETTLE also opens the first window.
          if (settle_cnt == SET_LAST) state_n = ST_MEASURE;
        end else if (cnt_expired) begin
          state_n = ST_FAIL;
        end
      end
      ST_MEASURE, ST_PASS: begin
        // Lock loss takes priority over a coincident window close.
        if (!locked_s) begin
          state_n = ST_IDLE;
        end else if (mon_rise) begin
          win_close = 1'b1;
          if (!win_good)
            state_n = ST_FAIL;
          else if (state == ST_MEASURE && good_cnt == GOOD_LAST)
            state_n = ST_PASS;
        end else if (cnt_expired) begin
          state_n = ST_FAIL;
        end
      end
      ST_FAIL: state_n = ST_FAIL;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      cnt         <= '0;
      settle_cnt  <= '0;
      good_cnt    <= '0;
      ratio_cnt   <= '0;
      ratio_valid <= 1'b0;
      err_cnt     <= '0;
    end else begin
      ratio_valid <= win_close;
      if (win_close) ratio_cnt <= cnt_len;
      if (win_close && !win_good && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;

      case (state)
        ST_SETTLE, ST_MEASURE, ST_PASS: cnt <= mon_rise ? '0 : cnt_len;
        default:                        cnt <= '0;
      endcase

      if (state_n != ST_SETTLE)                 settle_cnt <= '0;
      else if (state == ST_SETTLE && mon_rise)  settle_cnt <= settle_cnt + 1'b1;

      if (state_n != ST_MEASURE)                good_cnt <= '0;
      else if (win_close && win_good)           good_cnt <= good_cnt + 1'b1;
    end
  end

`ifdef CLK_CHK_TIMEOUT_EN
  // FAIL is entered either by a bad window close or by the watchdog; an
  // entry without a window close is therefore a timeout.
  logic timeout_q;
  always_ff @(posedge clk100) begin
    if (!rst_n)
      timeout_q <= 1'b0;
    else if (state != ST_FAIL && state_n == ST_FAIL && !win_close)
      timeout_q <= 1'b1;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);
  assign led  = pass;

endmodule

// File: tb/tb_clk_ratio_checker.sv
// tb_clk_ratio_checker
//   Drives a periodic mon_clk with a known divide ratio and checks the
//   checker's windows, pass/fail behaviour, lock loss, reset and stopped clock.
module tb_clk_ratio_checker;

  localparam int EXP    = 10;
  localparam int TOLV   = 0;
  localparam int SETTLE = 10;
  localparam int NMEAS  = 4;
  localparam int CW     = 16;
  localparam int TO_CYC = 20000;

  logic          clk100 = 1'b0;
  logic          rst_n  = 1'b0;
  logic          mon_clk = 1'b0;
  logic          locked = 1'b0;
  logic [CW-1:0] ratio_cnt;
  logic          ratio_valid;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [7:0]    err_cnt;
  logic          led;

  int errors = 0;
  int checks = 0;

  int mon_div   = 10;
  bit mon_run   = 1'b0;
  int mon_edges = 0;

  typedef struct {
    int cnt;
    bit pass_seen;
  } win_t;
  win_t wins[$];

  clk_ratio_checker dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .mon_clk     (mon_clk),
    .locked      (locked),
    .ratio_cnt   (ratio_cnt),
    .ratio_valid (ratio_valid),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .err_cnt     (err_cnt),
    .led         (led)
  );

  always #5 clk100 = ~clk100;

  // mon_clk = clk100 / mon_div, changing 3 ns after each clk100 edge.
  initial begin : mon_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk100);
      #3;
      if (mon_run) begin
        ph = (ph + 1) % mon_div;
        mon_clk = (ph < mon_div / 2);
      end else begin
        ph = 0;
        mon_clk = 1'b0;
      end
    end
  end

  always @(posedge mon_clk) mon_edges++;

  // Advance n cycles, recording every window report seen at the falling edge.
  task automatic tick(input int n);
    win_t w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk100);
      if (ratio_valid) begin
        w.cnt = int'(ratio_cnt);
        w.pass_seen = pass;
        wins.push_back(w);
      end
    end
  endtask

  task automatic wait_wins(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (wins.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    ok = (wins.size() >= n);
  endtask

  task automatic do_reset();
    @(negedge clk100);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    wins.delete();
  endtask

  // Reset, run a /10 clock, assert lock and wait for PASS.
  task automatic goto_pass(output bit ok);
    bit got;
    do_reset();
    mon_div = 10;
    mon_run = 1'b1;
    locked  = 1'b0;
    tick(100);
    #2;
    locked = 1'b1;
    wait_wins(NMEAS, (SETTLE + NMEAS + 3) * 10 + 50, got);
    tick(1);
    ok = got && (pass === 1'b1);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    locked  = 1'b1;
    mon_div = 10;
    mon_run = 1'b1;
    tick(30);
    checks++; if (ratio_cnt !== '0)  begin errors++; $display("FAIL reset_ratio_cnt: got %0d want 0", ratio_cnt); end
    checks++; if (ratio_valid !== 1'b0) begin errors++; $display("FAIL reset_ratio_valid: got %b want 0", ratio_valid); end
    checks++; if (pass !== 1'b0)     begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
    checks++; if (fail !== 1'b0)     begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
    checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (err_cnt !== 8'd0)  begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    checks++; if (led !== 1'b0)      begin errors++; $display("FAIL reset_led: got %b want 0", led); end
    locked = 1'b0;
    wins.delete();
  endtask

  // Lock with a /d clock; expected behaviour derived from |d-EXP| <= TOL.
  task automatic test_ratio(input int d);
    bit good, ok;
    int e0, edges, dev;
    dev  = (d > EXP) ? d - EXP : EXP - d;
    good = (dev <= TOLV);
    do_reset();
    mon_div = d;
    mon_run = 1'b1;
    locked  = 1'b0;
    tick(100 + $urandom_range(0, 50));
    #(1 + $urandom_range(0, 3));
    locked = 1'b1;
    e0 = mon_edges;
    wait_wins(1, (SETTLE + 3) * d + 50, ok);
    edges = mon_edges - e0;
    checks++; if (!ok) begin errors++; $display("FAIL first_window_d%0d: got none want a ratio_valid", d); end
    if (ok) begin
      checks++;
      if (edges < SETTLE + 1 || edges > SETTLE + 2) begin
        errors++; $display("FAIL settle_edges_d%0d: got %0d edges want %0d..%0d", d, edges, SETTLE + 1, SETTLE + 2);
      end
      checks++; if (wins[0].cnt != d) begin errors++; $display("FAIL first_ratio_d%0d: got %0d want %0d", d, wins[0].cnt, d); end
    end
    if (good) begin
      wait_wins(NMEAS, NMEAS * d + 50, ok);
      tick(1);
      checks++; if (!ok) begin errors++; $display("FAIL n_windows_d%0d: got %0d want %0d", d, wins.size(), NMEAS); end
      if (ok) begin
        for (int i = 0; i < NMEAS; i++) begin
          checks++;
          if (wins[i].cnt != d || wins[i].pass_seen != (i == NMEAS - 1)) begin
            errors++; $display("FAIL window%0d_d%0d: got cnt=%0d pass=%b want cnt=%0d pass=%b",
                                i, d, wins[i].cnt, wins[i].pass_seen, d, (i == NMEAS - 1));
          end
        end
      end
      checks++; if ({pass, led, fail, err_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
        errors++; $display("FAIL pass_state_d%0d: got pass=%b led=%b fail=%b err=%0d want 1 1 0 0", d, pass, led, fail, err_cnt);
      end
    end else begin
      tick(2);
      checks++; if ({fail, pass, led, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
        errors++; $display("FAIL fail_state_d%0d: got fail=%b pass=%b led=%b err=%0d want 1 0 0 1", d, fail, pass, led, err_cnt);
      end
      locked = 1'b0;
      tick(5 * d + 20);
      checks++; if (wins.size() != 1 || fail !== 1'b1 || err_cnt !== 8'd1) begin
        errors++; $display("FAIL fail_sticky_d%0d: got windows=%0d fail=%b err=%0d want 1 1 1", d, wins.size(), fail, err_cnt);
      end
    end
    locked = 1'b0;
  endtask

  task automatic test_idle_unlocked();
    do_reset();
    mon_div = 10;
    mon_run = 1'b1;
    locked  = 1'b0;
    tick(30000);
    checks++; if (wins.size() != 0) begin errors++; $display("FAIL idle_no_valid: got %0d windows want 0", wins.size()); end
    checks++; if ({pass, led, fail} !== 3'b000) begin
      errors++; $display("FAIL idle_outputs: got pass=%b led=%b fail=%b want 0 0 0", pass, led, fail);
    end
  endtask

  task automatic test_relock();
    bit ok;
    int e0, edges;
    goto_pass(ok);
    checks++; if (!ok) begin errors++; $display("FAIL relock_reach_pass: got pass=%b want 1", pass); end
    @(posedge clk100);
    #2;
    locked = 1'b0;
    tick(4);
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL relock_pass_drop: got %b want 0", pass); end
    wins.delete();
    tick(500);
    checks++; if (wins.size() != 0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL relock_unlocked: got windows=%0d pass=%b fail=%b want 0 0 0", wins.size(), pass, fail);
    end
    locked = 1'b1;
    e0 = mon_edges;
    wait_wins(NMEAS, (SETTLE + NMEAS + 3) * 10 + 50, ok);
    edges = mon_edges - e0;
    checks++; if (!ok) begin errors++; $display("FAIL relock_windows: got %0d want %0d", wins.size(), NMEAS); end
    if (ok) begin
      checks++;
      if (wins[NMEAS-1].pass_seen != 1'b1 || wins[NMEAS-2].pass_seen != 1'b0 || edges < SETTLE + NMEAS || edges > SETTLE + NMEAS + 1) begin
        errors++; $display("FAIL relock_pass_again: got pass_n=%b pass_n-1=%b edges=%0d want 1 0 %0d..%0d",
                            wins[NMEAS-1].pass_seen, wins[NMEAS-2].pass_seen, edges, SETTLE + NMEAS, SETTLE + NMEAS + 1);
      end
    end
    locked = 1'b0;
  endtask

  task automatic test_reset_mid_measure();
    bit ok;
    int e0, edges;
    do_reset();
    mon_div = 10;
    mon_run = 1'b1;
    tick(100);
    locked = 1'b1;
    wait_wins(2, (SETTLE + 5) * 10 + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_reach_measure: got %0d windows want 2", wins.size()); end
    tick($urandom_range(1, 8));
    @(posedge clk100);
    #2;
    rst_n = 1'b0;
    @(posedge clk100);
    e0 = mon_edges;
    #2;
    rst_n = 1'b1;
    @(negedge clk100);
    checks++; if ({ratio_cnt, ratio_valid, pass, fail, timeout, err_cnt, led} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got cnt=%0d v=%b p=%b f=%b t=%b e=%0d l=%b want all 0",
                          ratio_cnt, ratio_valid, pass, fail, timeout, err_cnt, led);
    end
    wins.delete();
    wait_wins(NMEAS, (SETTLE + NMEAS + 3) * 10 + 50, ok);
    edges = mon_edges - e0;
    checks++; if (!ok) begin errors++; $display("FAIL midreset_windows: got %0d want %0d", wins.size(), NMEAS); end
    if (ok) begin
      checks++;
      if (wins[NMEAS-1].pass_seen != 1'b1 || wins[NMEAS-2].pass_seen != 1'b0 || edges < SETTLE + NMEAS || edges > SETTLE + NMEAS + 1) begin
        errors++; $display("FAIL midreset_full_settle: got pass_n=%b pass_n-1=%b edges=%0d want 1 0 %0d..%0d",
                            wins[NMEAS-1].pass_seen, wins[NMEAS-2].pass_seen, edges, SETTLE + NMEAS, SETTLE + NMEAS + 1);
      end
    end
    locked = 1'b0;
  endtask

  task automatic test_stopped_mon();
    bit ok;
    goto_pass(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_reach_pass: got pass=%b want 1", pass); end
    mon_run = 1'b0;
    wins.delete();
    tick(TO_CYC + 200);
`ifdef CLK_CHK_TIMEOUT_EN
    checks++; if ({timeout, fail, pass, led} !== 4'b1100) begin
      errors++; $display("FAIL stop_timeout: got t=%b f=%b p=%b l=%b want 1 1 0 0", timeout, fail, pass, led);
    end
`else
    checks++; if ({timeout, fail, pass, led} !== 4'b0011) begin
      errors++; $display("FAIL stop_no_timeout: got t=%b f=%b p=%b l=%b want 0 0 1 1", timeout, fail, pass, led);
    end
    checks++; if (wins.size() != 0 || ratio_cnt !== CW'(10)) begin
      errors++; $display("FAIL stop_ratio_hold: got windows=%0d cnt=%0d want 0 10", wins.size(), ratio_cnt);
    end
`endif
    locked = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ratio(10);
    test_ratio(12);
    for (int k = 0; k < 3; k++) test_ratio(8 + int'($urandom_range(0, 6)));
    test_idle_unlocked();
    test_relock();
    test_reset_mid_measure();
    test_stopped_mon();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
